// File: rtl/dvi_video_sequencer_if.sv
// dvi_video_sequencer_if: pixel-source and TMDS-encoder side signals of the video sequencer
interface dvi_video_sequencer_if;
    logic        en;
    logic [23:0] pix_rgb;
    logic        pix_req;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        frame_start;
    logic        running;
    logic        enc_vde;
    logic [7:0]  enc_vd0;
    logic [7:0]  enc_vd1;
    logic [7:0]  enc_vd2;
    logic [1:0]  enc_cd0;
    logic [1:0]  enc_cd1;
    logic [1:0]  enc_cd2;
    modport master (
        input  en, pix_rgb,
        output pix_req, pix_x, pix_y, frame_start, running,
               enc_vde, enc_vd0, enc_vd1, enc_vd2, enc_cd0, enc_cd1, enc_cd2
    );
    modport slave (
        output en, pix_rgb,
        input  pix_req, pix_x, pix_y, frame_start, running,
               enc_vde, enc_vd0, enc_vd1, enc_vd2, enc_cd0, enc_cd1, enc_cd2
    );
endinterface

// File: rtl/dvi_video_sequencer.sv
// dvi_video_sequencer: video timing, pixel requests and latency-aligned TMDS encoder feed
module dvi_video_sequencer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_LAT  = 2
) (
    input logic clk,
    input logic rst,
    dvi_video_sequencer_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam logic [2:0] IDLE_W = {1'b0, ~VS_POL, ~HS_POL};

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096 || PIX_LAT < 1 || PIX_LAT > 8) begin : g_bad_cfg
            $error("dvi_video_sequencer: unsupported timing parameters");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [11:0] h, v, h_n, v_n;
    logic [31:0] hx, vx;
    logic        run, h_last, v_last, active, hs, vs;
    logic [2:0]  s0;
    logic [2:0]  dly [PIX_LAT];
    logic [2:0]  last;

    assign hx          = {20'd0, h};
    assign vx          = {20'd0, v};
    assign last        = dly[PIX_LAT-1];
    assign bus.pix_req = s0[2];
    assign bus.running = run;
    assign bus.enc_cd1 = 2'b00;
    assign bus.enc_cd2 = 2'b00;

    // next state, counter stepping and stage-0 decode of the current count
    always_comb begin
        run     = state == RUN;
        h_last  = hx == H_TOTAL - 1;
        v_last  = vx == V_TOTAL - 1;
        active  = run && hx < H_ACTIVE && vx < V_ACTIVE;
        hs      = run && hx >= HS_BEG && hx < HS_END;
        vs      = run && vx >= VS_BEG && vx < VS_END;
        state_n = state;
        if (!run && bus.en) state_n = RUN;
        if (run && h_last && v_last && !bus.en) state_n = IDLE;
        h_n     = (run && !h_last) ? h + 12'd1 : 12'd0;
        v_n     = !run ? 12'd0 : !h_last ? v : v_last ? 12'd0 : v + 12'd1;
    end

    // FSM state and raster counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            h     <= 12'd0;
            v     <= 12'd0;
        end else begin
            state <= state_n;
            h     <= h_n;
            v     <= v_n;
        end
    end

    // registered request, coordinates and stage-0 timing word
    always_ff @(posedge clk) begin
        if (rst) begin
            s0              <= IDLE_W;
            bus.pix_x       <= 12'd0;
            bus.pix_y       <= 12'd0;
            bus.frame_start <= 1'b0;
        end else begin
            s0              <= {active, vs ? VS_POL : ~VS_POL, hs ? HS_POL : ~HS_POL};
            bus.pix_x       <= h;
            bus.pix_y       <= v;
            bus.frame_start <= active && h == 12'd0 && v == 12'd0;
        end
    end

    // timing word travels alongside the pixel source latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIX_LAT; i++) dly[i] <= IDLE_W;
        end else begin
            dly[0] <= s0;
            for (int i = 1; i < PIX_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    // encoder output register: returned pixel joined with its delayed timing word
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.enc_vde <= 1'b0;
            bus.enc_vd0 <= 8'h00;
            bus.enc_vd1 <= 8'h00;
            bus.enc_vd2 <= 8'h00;
            bus.enc_cd0 <= IDLE_W[1:0];
        end else begin
            bus.enc_vde <= last[2];
            bus.enc_vd0 <= last[2] ? bus.pix_rgb[7:0] : 8'h00;
            bus.enc_vd1 <= last[2] ? bus.pix_rgb[15:8] : 8'h00;
            bus.enc_vd2 <= last[2] ? bus.pix_rgb[23:16] : 8'h00;
            bus.enc_cd0 <= last[1:0];
        end
    end
endmodule

// File: tb/tb_dvi_video_sequencer.sv
// tb_dvi_video_sequencer: scoreboard bench on a small 8x6 raster
module tb_dvi_video_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [24:0] exp_req [$];
    logic [23:0] exp_pix [$];
    logic [24:0] e_req;
    logic [23:0] e_pix;

    dvi_video_sequencer_if bus_a ();
    dvi_video_sequencer_if bus_b ();

    assign bus_b.en      = bus_a.en;
    assign bus_b.pix_rgb = bus_a.pix_rgb;

    dvi_video_sequencer #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(2))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    dvi_video_sequencer #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(2))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] pix_of(input logic [11:0] x, input logic [11:0] y);
        return {8'hA1 + y[7:0], 8'hB2 + x[7:0], 8'hC3 + {x[5:0], 2'b00} + y[7:0]};
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", n, cyc, a, e);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame();
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) begin
                exp_req.push_back({(x == 0 && y == 0) ? 1'b1 : 1'b0, 12'(y), 12'(x)});
                exp_pix.push_back(pix_of(12'(x), 12'(y)));
            end
    endtask

    task automatic chk_reset();
        chk("rst_pix_req", 32'(bus_a.pix_req), 0);
        chk("rst_pix_xy", {8'd0, bus_a.pix_y, bus_a.pix_x}, 0);
        chk("rst_frame_start", 32'(bus_a.frame_start), 0);
        chk("rst_running", 32'(bus_a.running), 0);
        chk("rst_vde", 32'(bus_a.enc_vde), 0);
        chk("rst_vd", {8'd0, bus_a.enc_vd2, bus_a.enc_vd1, bus_a.enc_vd0}, 0);
        chk("rst_cd0", 32'(bus_a.enc_cd0), 32'h3);
        chk("rst_cd12", {28'd0, bus_a.enc_cd2, bus_a.enc_cd1}, 0);
        chk("rst_cd0_pol1", 32'(bus_b.enc_cd0), 0);
    endtask

    // pixel source: answers each request exactly two cycles later, junk otherwise
    initial begin
        logic [24:0] r0, r1, r2;
        r0 = '0;
        r1 = '0;
        r2 = '0;
        forever begin
            @(posedge clk);
            #1;
            r2 = r1;
            r1 = r0;
            r0 = {bus_a.pix_req, bus_a.pix_y, bus_a.pix_x};
            bus_a.pix_rgb = r2[24] ? pix_of(r2[11:0], r2[23:12]) : 24'h5A5A5A;
        end
    end

    // monitor: pops expectations whenever the DUT presents a request or a video word
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.pix_req) begin
                if (exp_req.size() == 0) chk("req_unexpected", 1, 0);
                else begin
                    e_req = exp_req.pop_front();
                    chk("req_fs_y_x", {7'd0, bus_a.frame_start, bus_a.pix_y, bus_a.pix_x}, 32'(e_req));
                end
            end
            if (bus_a.enc_vde) begin
                if (exp_pix.size() == 0) chk("vde_unexpected", 1, 0);
                else begin
                    e_pix = exp_pix.pop_front();
                    chk("vde_rgb", {8'd0, bus_a.enc_vd2, bus_a.enc_vd1, bus_a.enc_vd0}, 32'(e_pix));
                end
            end else begin
                chk("blank_vd", {8'd0, bus_a.enc_vd2, bus_a.enc_vd1, bus_a.enc_vd0}, 0);
            end
        end
    end

    initial begin
        bus_a.en = 1'b0;
        bus_a.pix_rgb = '0;
        rst = 1'b1;
        at(2);
        chk_reset();
        at(3);
        rst = 1'b0;
        at(10);
        chk("idle_running", 32'(bus_a.running), 0);
        bus_a.en = 1'b1;
        push_frame();
        push_frame();
        at(11);
        chk("run_latency", 32'(bus_a.running), 1);
        chk("req_not_early", 32'(bus_a.pix_req), 0);
        at(12);
        chk("first_req", 32'(bus_a.pix_req), 1);
        chk("first_frame_start", 32'(bus_a.frame_start), 1);
        at(14);
        chk("vde_not_early", 32'(bus_a.enc_vde), 0);
        at(15);
        chk("first_vde", 32'(bus_a.enc_vde), 1);
        chk("first_rgb", {8'd0, bus_a.enc_vd2, bus_a.enc_vd1, bus_a.enc_vd0}, 32'hA1B2C3);
        at(16);
        chk("fs_one_cycle", 32'(bus_a.frame_start), 0);
        at(18);
        chk("last_vde_line0", 32'(bus_a.enc_vde), 1);
        at(19);
        chk("vde_end_line0", 32'(bus_a.enc_vde), 0);
        chk("cd0_pre_hsync", 32'(bus_a.enc_cd0), 32'h3);
        chk("cd0_pol1_pre_hsync", 32'(bus_b.enc_cd0), 0);
        at(20);
        chk("cd0_hsync_a", 32'(bus_a.enc_cd0), 32'h2);
        chk("cd0_pol1_hsync", 32'(bus_b.enc_cd0), 32'h1);
        at(21);
        chk("cd0_hsync_b", 32'(bus_a.enc_cd0), 32'h2);
        at(22);
        chk("cd0_post_hsync", 32'(bus_a.enc_cd0), 32'h3);
        at(28);
        chk("cd0_hsync_line1", 32'(bus_a.enc_cd0), 32'h2);
        at(29);
        chk("cd0_hsync_line1_b", 32'(bus_a.enc_cd0), 32'h2);
        at(36);
        chk("no_req_line3", 32'(bus_a.pix_req), 0);
        at(46);
        chk("cd0_pre_vsync", 32'(bus_a.enc_cd0), 32'h3);
        at(47);
        chk("cd0_vsync_start", 32'(bus_a.enc_cd0), 32'h1);
        at(50);
        chk("no_req_line4", 32'(bus_a.pix_req), 0);
        at(52);
        chk("cd0_both_sync", 32'(bus_a.enc_cd0), 0);
        chk("cd0_pol1_both_sync", 32'(bus_b.enc_cd0), 32'h3);
        at(55);
        chk("cd0_post_vsync", 32'(bus_a.enc_cd0), 32'h3);
        at(60);
        chk("frame1_req", 32'(bus_a.pix_req), 1);
        chk("frame1_start", 32'(bus_a.frame_start), 1);
        at(70);
        bus_a.en = 1'b0;
        at(106);
        chk("finish_frame_running", 32'(bus_a.running), 1);
        at(107);
        chk("stop_running", 32'(bus_a.running), 0);
        chk("stop_req", 32'(bus_a.pix_req), 0);
        at(110);
        chk("drain_vde", 32'(bus_a.enc_vde), 0);
        chk("drain_cd0", 32'(bus_a.enc_cd0), 32'h3);
        chk("drain_cd0_pol1", 32'(bus_b.enc_cd0), 0);
        at(115);
        chk("idle_cd0", 32'(bus_a.enc_cd0), 32'h3);
        chk("idle_running2", 32'(bus_a.running), 0);
        at(120);
        bus_a.en = 1'b1;
        push_frame();
        at(124);
        chk("abort_at_x2", 32'(bus_a.pix_x), 2);
        rst = 1'b1;
        exp_req.delete();
        exp_pix.delete();
        at(125);
        chk_reset();
        rst = 1'b0;
        push_frame();
        at(126);
        chk("restart_running", 32'(bus_a.running), 1);
        chk("flushed_vde_a", 32'(bus_a.enc_vde), 0);
        at(127);
        chk("restart_req", 32'(bus_a.pix_req), 1);
        chk("restart_fs", 32'(bus_a.frame_start), 1);
        chk("flushed_vde_b", 32'(bus_a.enc_vde), 0);
        at(130);
        chk("restart_vde", 32'(bus_a.enc_vde), 1);
        chk("restart_rgb", {8'd0, bus_a.enc_vd2, bus_a.enc_vd1, bus_a.enc_vd0}, 32'(pix_of(12'd0, 12'd0)));
        bus_a.en = 1'b0;
        at(173);
        chk("restart_frame_running", 32'(bus_a.running), 1);
        at(174);
        chk("restart_frame_stop", 32'(bus_a.running), 0);
        at(185);
        chk("req_queue_drained", exp_req.size(), 0);
        chk("pix_queue_drained", exp_pix.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
